control_pipe: RTL and testbench

//  Pipelined successor of the single-cycle main decoder. Decodes the 7-bit RV32 opcode in ID.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/ctrl_decode.sv | 86 ++++++++
 rtl/control_pipe.sv | 83 ++++++++
 tb/tb_control_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, ALUop codes and pipelined control-word layout
package ctrl_pkg;

    localparam logic [6:0] OP_NOP    = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_PASSB  = 2'b11;

    // Each stage only carries the fields still needed downstream.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic link;
    } wb_ctrl_t;

    typedef struct packed {
        logic     mem_read;
        logic     mem_write;
        wb_ctrl_t wb;
    } mem_ctrl_t;

    typedef struct packed {
        logic       alu_src;
        logic       asel_pc;
        logic [1:0] alu_op;
        logic       branch;
        logic       jump;
        logic       jump_reg;
        mem_ctrl_t  mem;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;
    localparam mem_ctrl_t  MEM_NOP  = '0;
    localparam wb_ctrl_t   WB_NOP   = '0;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-word decoder
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_EN = 1
) (
    input  logic [6:0]  opcode,
    output ctrl_word_t  ctrl,
    output logic        illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LOAD: begin
                ctrl.alu_src           = 1'b1;
                ctrl.alu_op            = ALUOP_ADD;
                ctrl.mem.mem_read      = 1'b1;
                ctrl.mem.wb.reg_write  = 1'b1;
                ctrl.mem.wb.mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                ctrl.alu_src       = 1'b1;
                ctrl.alu_op        = ALUOP_ADD;
                ctrl.mem.mem_write = 1'b1;
            end
            OP_RTYPE: begin
                ctrl.alu_op           = ALUOP_FUNCT;
                ctrl.mem.wb.reg_write = 1'b1;
            end
            OP_ITYPE: begin
                ctrl.alu_src          = 1'b1;
                ctrl.alu_op           = ALUOP_FUNCT;
                ctrl.mem.wb.reg_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_BRANCH;
            end
            OP_JAL: begin
                if (EXT_EN != 0) begin
                    ctrl.asel_pc          = 1'b1;
                    ctrl.jump             = 1'b1;
                    ctrl.mem.wb.reg_write = 1'b1;
                    ctrl.mem.wb.link      = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JALR: begin
                if (EXT_EN != 0) begin
                    ctrl.alu_src          = 1'b1;
                    ctrl.jump             = 1'b1;
                    ctrl.jump_reg         = 1'b1;
                    ctrl.mem.wb.reg_write = 1'b1;
                    ctrl.mem.wb.link      = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_EN != 0) begin
                    ctrl.alu_src          = 1'b1;
                    ctrl.alu_op           = ALUOP_PASSB;
                    ctrl.mem.wb.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (EXT_EN != 0) begin
                    ctrl.alu_src          = 1'b1;
                    ctrl.asel_pc          = 1'b1;
                    ctrl.alu_op           = ALUOP_ADD;
                    ctrl.mem.wb.reg_write = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - pipelined main decoder with ID/EX, EX/MEM, MEM/WB control registers
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W = 2,
    parameter int EXT_EN  = 1,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               hazard_stall,
    input  logic               flush,
    input  logic               freeze,
    output logic               ex_ALUSrc,
    output logic               ex_ASelPC,
    output logic [ALUOP_W-1:0] ex_ALUop,
    output logic               ex_Branch,
    output logic               ex_Jump,
    output logic               ex_JumpReg,
    output logic               mem_MemRead,
    output logic               mem_MemWrite,
    output logic               wb_RegWrite,
    output logic               wb_MemtoReg,
    output logic               wb_Link,
    output logic               ex_illegal,
    output logic [CNT_W-1:0]   illegal_cnt
);

    ctrl_word_t id_ctrl;
    logic       id_illegal;
    ctrl_word_t id_ex;
    mem_ctrl_t  ex_mem;
    wb_ctrl_t   mem_wb;

    ctrl_decode #(.EXT_EN(EXT_EN)) u_decode (
        .opcode  (opcode),
        .ctrl    (id_ctrl),
        .illegal (id_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex       <= CTRL_NOP;
            ex_illegal  <= 1'b0;
            ex_mem      <= MEM_NOP;
            mem_wb      <= WB_NOP;
            illegal_cnt <= '0;
        end else if (!freeze) begin
            // The instruction currently in EX is counted even if a flush squashes younger slots.
            if (ex_illegal && (illegal_cnt != '1))
                illegal_cnt <= illegal_cnt + CNT_W'(1);
            mem_wb <= ex_mem.wb;
            if (flush) begin
                id_ex      <= CTRL_NOP;
                ex_illegal <= 1'b0;
                ex_mem     <= MEM_NOP;
            end else begin
                ex_mem <= id_ex.mem;
                if (hazard_stall) begin
                    id_ex      <= CTRL_NOP;
                    ex_illegal <= 1'b0;
                end else begin
                    id_ex      <= id_ctrl;
                    ex_illegal <= id_illegal;
                end
            end
        end
    end

    assign ex_ALUSrc    = id_ex.alu_src;
    assign ex_ASelPC    = id_ex.asel_pc;
    assign ex_ALUop     = ALUOP_W'(id_ex.alu_op);
    assign ex_Branch    = id_ex.branch;
    assign ex_Jump      = id_ex.jump;
    assign ex_JumpReg   = id_ex.jump_reg;
    assign mem_MemRead  = ex_mem.mem_read;
    assign mem_MemWrite = ex_mem.mem_write;
    assign wb_RegWrite  = mem_wb.reg_write;
    assign wb_MemtoReg  = mem_wb.mem_to_reg;
    assign wb_Link      = mem_wb.link;

endmodule

// File: tb/tb_control_pipe.sv
// tb/tb_control_pipe.sv - randomized model-checked bench for control_pipe
module tb_control_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       hazard_stall = 1'b0, flush = 1'b0, freeze = 1'b0;

    logic       a_alusrc, a_aselpc, a_branch, a_jump, a_jumpreg;
    logic [1:0] a_aluop;
    logic       a_memread, a_memwrite, a_regwrite, a_memtoreg, a_link, a_illegal;
    logic [7:0] a_cnt;

    logic       b_alusrc, b_aselpc, b_branch, b_jump, b_jumpreg;
    logic [1:0] b_aluop;
    logic       b_memread, b_memwrite, b_regwrite, b_memtoreg, b_link, b_illegal;
    logic [1:0] b_cnt;

    always #5 clk = ~clk;

    control_pipe #(.ALUOP_W(2), .EXT_EN(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .hazard_stall(hazard_stall),
        .flush(flush), .freeze(freeze),
        .ex_ALUSrc(a_alusrc), .ex_ASelPC(a_aselpc), .ex_ALUop(a_aluop),
        .ex_Branch(a_branch), .ex_Jump(a_jump), .ex_JumpReg(a_jumpreg),
        .mem_MemRead(a_memread), .mem_MemWrite(a_memwrite),
        .wb_RegWrite(a_regwrite), .wb_MemtoReg(a_memtoreg), .wb_Link(a_link),
        .ex_illegal(a_illegal), .illegal_cnt(a_cnt)
    );

    control_pipe #(.ALUOP_W(2), .EXT_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .hazard_stall(hazard_stall),
        .flush(flush), .freeze(freeze),
        .ex_ALUSrc(b_alusrc), .ex_ASelPC(b_aselpc), .ex_ALUop(b_aluop),
        .ex_Branch(b_branch), .ex_Jump(b_jump), .ex_JumpReg(b_jumpreg),
        .mem_MemRead(b_memread), .mem_MemWrite(b_memwrite),
        .wb_RegWrite(b_regwrite), .wb_MemtoReg(b_memtoreg), .wb_Link(b_link),
        .ex_illegal(b_illegal), .illegal_cnt(b_cnt)
    );

    typedef struct {
        bit       alusrc, aselpc, branch, jump, jumpreg;
        bit [1:0] aluop;
        bit       memread, memwrite, regwrite, memtoreg, link, illegal;
    } dec_t;

    // Model: each stage holds the opcode occupying it; bubbles are opcode 0.
    int ex_op = 0, mem_op = 0, wb_op = 0;
    int cnt_a = 0, cnt_b = 0;
    int n_cmp = 0, n_err = 0;

    function automatic dec_t dec(input int op, input bit ext);
        dec_t d = '{default: 0};
        case (op)
            'h00: ;
            'h03: begin d.alusrc = 1; d.memtoreg = 1; d.regwrite = 1; d.memread = 1; end
            'h23: begin d.alusrc = 1; d.memwrite = 1; end
            'h33: begin d.regwrite = 1; d.aluop = 2; end
            'h13: begin d.alusrc = 1; d.regwrite = 1; d.aluop = 2; end
            'h63: begin d.branch = 1; d.aluop = 1; end
            'h6F: if (ext) begin d.aselpc = 1; d.jump = 1; d.regwrite = 1; d.link = 1; end
                  else d.illegal = 1;
            'h67: if (ext) begin d.alusrc = 1; d.jump = 1; d.jumpreg = 1; d.regwrite = 1; d.link = 1; end
                  else d.illegal = 1;
            'h37: if (ext) begin d.alusrc = 1; d.regwrite = 1; d.aluop = 3; end
                  else d.illegal = 1;
            'h17: if (ext) begin d.alusrc = 1; d.aselpc = 1; d.regwrite = 1; end
                  else d.illegal = 1;
            default: d.illegal = 1;
        endcase
        return d;
    endfunction

    function automatic logic [20:0] model_vec(input bit ext, input int cnt);
        dec_t e = dec(ex_op, ext);
        dec_t m = dec(mem_op, ext);
        dec_t w = dec(wb_op, ext);
        logic [7:0] c = 8'(cnt);
        return {e.alusrc, e.aselpc, e.aluop, e.branch, e.jump, e.jumpreg,
                m.memread, m.memwrite, w.regwrite, w.memtoreg, w.link, e.illegal, c};
    endfunction

    function automatic logic [20:0] vec_a();
        return {a_alusrc, a_aselpc, a_aluop, a_branch, a_jump, a_jumpreg,
                a_memread, a_memwrite, a_regwrite, a_memtoreg, a_link, a_illegal, a_cnt};
    endfunction

    function automatic logic [20:0] vec_b();
        return {b_alusrc, b_aselpc, b_aluop, b_branch, b_jump, b_jumpreg,
                b_memread, b_memwrite, b_regwrite, b_memtoreg, b_link, b_illegal, 6'd0, b_cnt};
    endfunction

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int nxt = int'(opcode);
        if (reset) begin
            ex_op = 0; mem_op = 0; wb_op = 0; cnt_a = 0; cnt_b = 0;
        end else if (!freeze) begin
            if (dec(ex_op, 1'b1).illegal && cnt_a < 255) cnt_a++;
            if (dec(ex_op, 1'b0).illegal && cnt_b < 3) cnt_b++;
            wb_op = mem_op;
            if (flush) begin
                mem_op = 0; ex_op = 0;
            end else begin
                mem_op = ex_op;
                ex_op  = hazard_stall ? 0 : nxt;
            end
        end
    endtask

    // Drive inputs, let the edge happen, update the model, then compare on the falling edge.
    task automatic tick(input logic [6:0] op, input bit st, input bit fl, input bit fr, input bit rs);
        opcode = op; hazard_stall = st; flush = fl; freeze = fr; reset = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_ext1", vec_a(), model_vec(1'b1, cnt_a));
        chk("model_ext0", vec_b(), model_vec(1'b0, cnt_b));
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(7'h00, 0, 0, 0, 0);
    endtask

    localparam logic [6:0] OPS [10] = '{7'h00, 7'h03, 7'h23, 7'h33, 7'h13,
                                        7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    initial begin
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        tick(7'h00, 0, 0, 0, 1);
        tick(7'h00, 0, 0, 0, 1);
        chk("reset_state", vec_a(), 21'd0);

        // load flowing through the stages
        tick(7'h03, 0, 0, 0, 0);
        chk("lw_ex_alusrc", 21'(a_alusrc), 21'd1);
        tick(7'h00, 0, 0, 0, 0);
        chk("lw_mem_read", 21'(a_memread), 21'd1);
        tick(7'h00, 0, 0, 0, 0);
        chk("lw_wb", 21'({a_regwrite, a_memtoreg, a_link}), 21'b110);

        // load-use bubble
        tick(7'h03, 0, 0, 0, 0);
        tick(7'h33, 1, 0, 0, 0);
        chk("stall_ex_zero", 21'({a_alusrc, a_aluop, a_illegal}), 21'd0);
        tick(7'h33, 0, 0, 0, 0);
        chk("after_stall_aluop", 21'(a_aluop), 21'd2);

        // flush with branch in EX/MEM and add in ID/EX
        tick(7'h63, 0, 0, 0, 0);
        tick(7'h33, 0, 0, 0, 0);
        tick(7'h13, 0, 1, 0, 0);
        chk("flush_ex_mem", 21'({a_aluop, a_branch, a_alusrc, a_memread, a_memwrite}), 21'd0);
        chk("flush_wb_branch", 21'({a_regwrite, a_memtoreg, a_link}), 21'd0);
        nop(3);

        // JAL with and without extension decode
        tick(7'h6F, 0, 0, 0, 0);
        chk("jal_ex", 21'({a_jump, a_aselpc, a_illegal}), 21'b110);
        chk("jal_b_illegal", 21'({b_illegal, b_cnt}), 21'b100);
        tick(7'h00, 0, 0, 0, 0);
        chk("jal_b_cnt", 21'(b_cnt), 21'd1);
        tick(7'h00, 0, 0, 0, 0);
        chk("jal_wb", 21'({a_link, a_regwrite}), 21'b11);

        // freeze with a flush request held during it
        tick(7'h03, 0, 0, 0, 0);
        tick(7'h23, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(7'h23, 0, 1, 1, 0);
            chk("freeze_hold", 21'({a_memread, a_memwrite, a_alusrc}), 21'b101);
        end
        nop(3);

        // saturating counter on the narrow instance
        tick(7'h00, 0, 0, 0, 1);
        tick(7'h7F, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick((i < 4) ? 7'h7F : 7'h00, 0, 0, 0, 0);
            chk("sat_cnt", 21'(b_cnt), 21'(exp_seq[i]));
        end
        tick(7'h7F, 0, 0, 0, 1);
        chk("reset_clears", {vec_b()}, 21'd0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] op;
            if ($urandom_range(0, 3) != 0) op = OPS[$urandom_range(0, 9)];
            else op = 7'($urandom);
            tick(op, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
